// File: rtl/serial_addsub_pkg.sv
// Shared op-codes, FSM state encodings and result-flag type for the serial add/subtract unit.
package serial_addsub_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  typedef struct packed {
    logic cf;
    logic ovf;
    logic zf;
    logic nf;
  } flags_t;

  // Subtraction is a + ~b + 1, so the borrow-in inverts into the initial carry.
  function automatic logic init_carry(input logic [1:0] op, input logic cin);
    logic c;
    unique case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      OP_ADC:  c = cin;
      default: c = ~cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// W-bit combinational adder slice with carry in/out; the single arithmetic element of the unit.
module chunk_add #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  always_comb begin
    {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle N-bit add/subtract: W bits per clock, LSB chunk first, valid/ready on both sides.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cf,
  output logic         ovf,
  output logic         zf,
  output logic         nf
);

  localparam int unsigned Chunks = N / W;
  localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Chunks - 1);

  if ((W == 0) || (N % W != 0)) begin : g_bad_width
    $error("serial_addsub: N must be a non-zero multiple of W");
  end

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic            zacc_q, zacc_d;
  logic            sub_q, sub_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    sum_q, sum_d;
  flags_t          flags_q, flags_d;

  logic [W-1:0]    chunk_s;
  logic            chunk_cout;

  chunk_add #(
    .W(W)
  ) u_chunk_add (
    .a_i   (a_q[W-1:0]),
    .b_i   (b_q[W-1:0]),
    .cin_i (carry_q),
    .s_o   (chunk_s),
    .cout_o(chunk_cout)
  );

  always_comb begin
    in_ready = clr_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));

    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    flags_d     = flags_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          cnt_d   = '0;
          a_d     = a;
          b_d     = op[0] ? ~b : b;
          carry_d = init_carry(op, cin);
          zacc_d  = 1'b1;
          sub_d   = op[0];
        end
      end
      StRun: begin
        // Operands drain from the bottom while result chunks enter from the top.
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        res_d   = (res_q >> W) | (N'(chunk_s) << (N - W));
        carry_d = chunk_cout;
        zacc_d  = zacc_q & (chunk_s == '0);
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d     = StDone;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          sum_d       = res_d;
          flags_d.cf  = sub_q ^ chunk_cout;
          flags_d.ovf = (a_q[W-1] == b_q[W-1]) & (chunk_s[W-1] != a_q[W-1]);
          flags_d.zf  = zacc_d;
          flags_d.nf  = chunk_s[W-1];
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            state_d = StRun;
            cnt_d   = '0;
            a_d     = a;
            b_d     = op[0] ? ~b : b;
            carry_d = init_carry(op, cin);
            zacc_d  = 1'b1;
            sub_d   = op[0];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cf        = flags_q.cf;
  assign ovf       = flags_q.ovf;
  assign zf        = flags_q.zf;
  assign nf        = flags_q.nf;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (W = 8, 32, 4), arithmetic reference model, scoreboard.
module tb_serial_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cf;
    logic        ovf;
    logic        zf;
    logic        nf;
  } res_t;

  typedef struct packed {
    logic [1:0] lane;
    res_t       r;
  } sb_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    logic        tog;
    logic [31:0] es;
    logic [3:0]  ef;
  } vec_t;

  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        iv[3];
  logic        ir[3];
  logic        ordy[3];
  logic        ov[3];
  logic [31:0] a_s[3];
  logic [31:0] b_s[3];
  logic [1:0]  op_s[3];
  logic        cin_s[3];
  logic [31:0] sum_w[3];
  logic        cf_w[3];
  logic        ovf_w[3];
  logic        zf_w[3];
  logic        nf_w[3];

  int n_checks = 0;
  int n_fail   = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned WL = (k == 0) ? 8 : ((k == 1) ? 32 : 4);
    serial_addsub #(
      .N(32),
      .W(WL)
    ) u_dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .in_valid (iv[k]),
      .in_ready (ir[k]),
      .a        (a_s[k]),
      .b        (b_s[k]),
      .op       (op_s[k]),
      .cin      (cin_s[k]),
      .out_valid(ov[k]),
      .out_ready(ordy[k]),
      .sum      (sum_w[k]),
      .cf       (cf_w[k]),
      .ovf      (ovf_w[k]),
      .zf       (zf_w[k]),
      .nf       (nf_w[k])
    );
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int chunks_of(input int lane);
    case (lane)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: plain unsigned/signed arithmetic on the full operands.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic cin);
    res_t        r;
    logic        ci;
    logic [32:0] wide;
    longint      sr;
    ci = op[1] ? cin : 1'b0;
    if (!op[0]) begin
      wide = {1'b0, a} + {1'b0, b} + 33'(ci);
      sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    end else begin
      wide = {1'b0, a} - {1'b0, b} - 33'(ci);
      sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
    end
    r.sum = wide[31:0];
    r.cf  = wide[32];
    r.ovf = (sr > SMax) || (sr < SMin);
    r.zf  = (r.sum == 32'h0);
    r.nf  = r.sum[31];
    return r;
  endfunction

  // Compare process: checks each new result, output stability and the handshake rules.
  res_t last[3];
  logic was_ov[3];
  logic was_rdy[3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!clr_n) begin
        last[k]    = '0;
        was_ov[k]  = 1'b0;
        was_rdy[k] = 1'b0;
      end else begin
        if (ov[k] && !was_ov[k]) begin
          if ((sb.size() == 0) || (int'(sb[0].lane) != k)) begin
            check("unexpected_result", 64'(k), 64'(99));
          end else begin
            last[k] = sb[0].r;
          end
        end
        check("outputs", 64'({sum_w[k], cf_w[k], ovf_w[k], zf_w[k], nf_w[k]}), 64'(last[k]));
        if (was_ov[k] && !was_rdy[k]) check("valid_held", 64'(ov[k]), 64'(1));
        if (ov[k] && ordy[k] && (sb.size() != 0) && (int'(sb[0].lane) == k)) void'(sb.pop_front());
        was_ov[k]  = ov[k];
        was_rdy[k] = ordy[k];
      end
    end
  end

  task automatic drive(input int lane, input vec_t v);
    a_s[lane]   = v.a;
    b_s[lane]   = v.b;
    op_s[lane]  = v.op;
    cin_s[lane] = v.cin;
  endtask

  task automatic wait_valid(input int lane, input bit tog, input string name);
    int j;
    for (j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (tog) begin
        op_s[lane]  = ~op_s[lane];
        cin_s[lane] = ~cin_s[lane];
        a_s[lane]   = ~a_s[lane];
        b_s[lane]   = b_s[lane] + 32'd1;
      end
      if (ov[lane]) break;
    end
    check(name, 64'(j), 64'(chunks_of(lane)));
  endtask

  task automatic run_op(input int lane, input vec_t v);
    res_t m;
    bit   got;
    m = model(v.a, v.b, v.op, v.cin);
    check("model_sum", 64'(m.sum), 64'(v.es));
    check("model_flags", 64'({m.cf, m.ovf, m.zf, m.nf}), 64'(v.ef));
    drive(lane, v);
    iv[lane]   = 1'b1;
    ordy[lane] = 1'b1;
    got = 1'b0;
    for (int j = 0; j < 20 && !got; j++) begin
      @(negedge clk);
      got = ir[lane];
    end
    check("accept_ready", 64'(got), 64'(1));
    sb.push_back({2'(lane), m});
    @(posedge clk); #1;
    iv[lane] = 1'b0;
    wait_valid(lane, v.tog, "latency");
    @(posedge clk); #1;
  endtask

  task automatic stream(input int lane);
    vec_t sv[3];
    int   idx, last_t, seen;
    bit   acc;
    sv[0] = '{32'h01020304, 32'h10203040, 2'b00, 1'b0, 1'b0, 32'h0, 4'h0};
    sv[1] = '{32'h00000000, 32'h00000001, 2'b01, 1'b0, 1'b0, 32'h0, 4'h0};
    sv[2] = '{32'h80000000, 32'h00000000, 2'b11, 1'b1, 1'b0, 32'h0, 4'h0};
    idx = 0; last_t = -1; seen = 0;
    drive(lane, sv[0]);
    iv[lane]   = 1'b1;
    ordy[lane] = 1'b1;
    for (int cyc = 0; cyc < 80 && seen < 3; cyc++) begin
      @(negedge clk);
      acc = iv[lane] && ir[lane];
      if (acc) sb.push_back({2'(lane), model(sv[idx].a, sv[idx].b, sv[idx].op, sv[idx].cin)});
      if (ov[lane]) begin
        if (last_t >= 0) check("stream_period", 64'(cyc - last_t), 64'(chunks_of(lane) + 1));
        last_t = cyc;
        seen++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) drive(lane, sv[idx]);
        else iv[lane] = 1'b0;
      end
    end
    check("stream_count", 64'(seen), 64'(3));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, 1'b0, 32'h00000000, 4'b1010};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, 1'b0, 32'h80000000, 4'b0101};
    vecs[2] = '{32'h80000000, 32'h00000001, 2'b01, 1'b0, 1'b0, 32'h7FFFFFFF, 4'b0100};
    vecs[3] = '{32'h00000005, 32'h00000007, 2'b01, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b1001};
    vecs[4] = '{32'h00000007, 32'h00000007, 2'b01, 1'b0, 1'b0, 32'h00000000, 4'b0010};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000000, 2'b10, 1'b1, 1'b0, 32'h00000000, 4'b1010};
    vecs[6] = '{32'h00000000, 32'h00000000, 2'b11, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b1001};
    vecs[7] = '{32'h12345678, 32'h11111111, 2'b10, 1'b1, 1'b1, 32'h2345678A, 4'b0000};
    vecs[8] = '{32'h00000010, 32'h00000003, 2'b11, 1'b0, 1'b1, 32'h0000000D, 4'b0000};

    clr_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; a_s[k] = '0; b_s[k] = '0; op_s[k] = '0; cin_s[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", 64'(ov[k]), 64'(0));
      check("rst_in_ready", 64'(ir[k]), 64'(0));
      check("rst_outputs", 64'({sum_w[k], cf_w[k], ovf_w[k], zf_w[k], nf_w[k]}), 64'(0));
    end
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check("idle_in_ready", 64'(ir[k]), 64'(1));
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++) run_op(k, vecs[i]);
      stream(k);
    end

    // Backpressure on lane 0, then accept in the same cycle the result is taken.
    v = '{32'h00000010, 32'h00000020, 2'b00, 1'b0, 1'b0, 32'h30, 4'h0};
    drive(0, v);
    iv[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    check("bp_accept_ready", 64'(ir[0]), 64'(1));
    sb.push_back({2'(0), model(v.a, v.b, v.op, v.cin)});
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_valid(0, 1'b0, "bp_latency");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(ov[0]), 64'(1));
      check("bp_in_ready", 64'(ir[0]), 64'(0));
    end
    @(posedge clk); #1;
    v = '{32'h00000100, 32'h00000001, 2'b01, 1'b0, 1'b0, 32'hFF, 4'h0};
    drive(0, v);
    iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", 64'(ir[0]), 64'(1));
    sb.push_back({2'(0), model(v.a, v.b, v.op, v.cin)});
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_valid(0, 1'b0, "b2b_latency");
    check("b2b_sum", 64'(sum_w[0]), 64'(32'hFF));
    @(posedge clk); #1;

    // Reset while chunk 2 is in flight discards the operation.
    v = '{32'h0000FFFF, 32'h00010001, 2'b00, 1'b0, 1'b0, 32'h0, 4'h0};
    drive(0, v);
    iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    check("rr_accept_ready", 64'(ir[0]), 64'(1));
    sb.push_back({2'(0), model(v.a, v.b, v.op, v.cin)});
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check("rr_out_valid", 64'(ov[0]), 64'(0));
    check("rr_outputs", 64'({sum_w[0], cf_w[0], ovf_w[0], zf_w[0], nf_w[0]}), 64'(0));
    check("rr_in_ready_low", 64'(ir[0]), 64'(0));
    sb.delete();
    @(posedge clk); #2;
    clr_n = 1'b1;
    #1;
    check("rr_in_ready", 64'(ir[0]), 64'(1));
    check("rr_no_output", 64'(ov[0]), 64'(0));
    @(posedge clk); #1;
    run_op(0, '{32'h00000001, 32'h00000002, 2'b00, 1'b1, 1'b0, 32'h00000003, 4'b0000});
    check("rr_sum", 64'(sum_w[0]), 64'(3));

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
